// File: rtl/uart_tx.sv
// uart_tx: 8N1-style serial transmitter clocked by the shared 16x baud tick.
// A one-cycle start strobe latches a byte, which is sent LSB-first framed by a
// low start bit and STOP_BITS high stop bits. All outputs are registered.
module uart_tx #(
  parameter int unsigned SAMPLING_COUNTER_LIMIT = 16,
  parameter int unsigned DATA_WIDTH             = 8,
  parameter int unsigned STOP_BITS              = 1
) (
  input  logic                  I_sys_clk,
  input  logic                  I_rst,
  input  logic                  I_baud_tick,
  input  logic [DATA_WIDTH-1:0] I_tx_data,
  input  logic                  I_tx_start,
  output logic                  o_tx_serial_data,
  output logic                  o_tx_busy,
  output logic                  o_tx_done
);

  localparam int unsigned TICK_W  = $clog2(SAMPLING_COUNTER_LIMIT);
  localparam int unsigned BIT_MAX = (DATA_WIDTH > STOP_BITS) ? DATA_WIDTH : STOP_BITS;
  localparam int unsigned BIT_W   = (BIT_MAX > 1) ? $clog2(BIT_MAX) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(SAMPLING_COUNTER_LIMIT - 1);
  localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
  localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

  typedef enum logic [3:0] {
    IDLE  = 4'b0001,
    START = 4'b0010,
    DATA  = 4'b0100,
    STOP  = 4'b1000
  } state_t;

  state_t                state, state_nxt;
  logic [TICK_W-1:0]     tick_cnt, tick_nxt;
  logic [BIT_W-1:0]      bit_cnt, bit_nxt;
  logic [DATA_WIDTH-1:0] shift_reg, shift_nxt;
  logic                  line_nxt, busy_nxt, done_nxt;
  logic                  bit_end;

  // A bit period closes on the tick that sees the counter at its last value.
  assign bit_end = I_baud_tick && (tick_cnt == TICK_LAST);

  // Next-state, counter, shifter and next-output decode.
  always_comb begin
    // NOTE: every output of this block gets a default first so that no path
    // through the case statement leaves a variable unassigned (no latches).
    state_nxt = state;
    tick_nxt  = tick_cnt;
    bit_nxt   = bit_cnt;
    shift_nxt = shift_reg;
    line_nxt  = 1'b1;
    busy_nxt  = 1'b0;
    done_nxt  = 1'b0;

    // The baud counter runs in every active state and wraps at each bit end.
    if (state != IDLE && I_baud_tick) begin
      tick_nxt = bit_end ? '0 : tick_cnt + TICK_W'(1);
    end

    case (state)
      IDLE: begin
        if (I_tx_start) begin
          shift_nxt = I_tx_data;
          tick_nxt  = '0;
          bit_nxt   = '0;
          state_nxt = START;
          line_nxt  = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      START: begin
        line_nxt = 1'b0;
        busy_nxt = 1'b1;
        if (bit_end) begin
          state_nxt = DATA;
          line_nxt  = shift_reg[0];
        end
      end
      DATA: begin
        line_nxt = shift_reg[0];
        busy_nxt = 1'b1;
        if (bit_end) begin
          shift_nxt = shift_reg >> 1;
          if (bit_cnt == DATA_LAST) begin
            bit_nxt   = '0;
            state_nxt = STOP;
            line_nxt  = 1'b1;
          end else begin
            bit_nxt  = bit_cnt + BIT_W'(1);
            line_nxt = shift_nxt[0];
          end
        end
      end
      STOP: begin
        line_nxt = 1'b1;
        busy_nxt = 1'b1;
        if (bit_end) begin
          if (bit_cnt == STOP_LAST) begin
            bit_nxt   = '0;
            state_nxt = IDLE;
            busy_nxt  = 1'b0;
            done_nxt  = 1'b1;
          end else begin
            bit_nxt = bit_cnt + BIT_W'(1);
          end
        end
      end
      default: begin
        // Corrupted one-hot encoding: park in IDLE with the line high.
        state_nxt = IDLE;
        tick_nxt  = '0;
        bit_nxt   = '0;
      end
    endcase
  end

  // State, datapath and output registers; reset wins over every other input.
  always_ff @(posedge I_sys_clk) begin
    // NOTE: registers are updated with non-blocking assignments so every
    // flop samples the pre-edge values, independent of statement order.
    if (I_rst) begin
      state            <= IDLE;
      tick_cnt         <= '0;
      bit_cnt          <= '0;
      shift_reg        <= '0;
      o_tx_serial_data <= 1'b1;
      o_tx_busy        <= 1'b0;
      o_tx_done        <= 1'b0;
    end else begin
      state            <= state_nxt;
      tick_cnt         <= tick_nxt;
      bit_cnt          <= bit_nxt;
      shift_reg        <= shift_nxt;
      o_tx_serial_data <= line_nxt;
      o_tx_busy        <= busy_nxt;
      o_tx_done        <= done_nxt;
    end
  end

endmodule
